// File: rtl/id_ex_pipe_reg_pkg.sv
// id_ex_pipe_reg_pkg: shared widths and pipeline-stage FSM encodings for the ID/EX register
package id_ex_pipe_reg_pkg;
    localparam int DEFAULT_REG_ADDRESS_LENGTH = 5;
    localparam int ALU_OP_WIDTH = 4;
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HOLD   = 2'd2
    } pipeStateT;
endpackage

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the destination of a load sitting in EX
module load_use_detect
    import id_ex_pipe_reg_pkg::*;
#(
    parameter int REG_ADDRESS_LENGTH = DEFAULT_REG_ADDRESS_LENGTH
) (
    input  logic                          exValid,
    input  logic                          exMemRead,
    input  logic [REG_ADDRESS_LENGTH-1:0] exDest,
    input  logic                          idValid,
    input  logic [REG_ADDRESS_LENGTH-1:0] idRs,
    input  logic [REG_ADDRESS_LENGTH-1:0] idRt,
    output logic                          luHit
);
    // r0 is hardwired zero, so a load targeting it can never create a dependency
    assign luHit = exValid & exMemRead & (exDest != '0) & idValid & ((exDest == idRs) | (exDest == idRt));
endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with flush, external stall and load-use bubble insertion
module id_ex_pipe_reg
    import id_ex_pipe_reg_pkg::*;
#(
    parameter int REG_ADDRESS_LENGTH = DEFAULT_REG_ADDRESS_LENGTH,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [REG_ADDRESS_LENGTH-1:0] id_rs,
    input  logic [REG_ADDRESS_LENGTH-1:0] id_rt,
    input  logic [REG_ADDRESS_LENGTH-1:0] id_rd,
    input  logic [DATA_WIDTH-1:0]         id_rs_data,
    input  logic [DATA_WIDTH-1:0]         id_rt_data,
    input  logic [DATA_WIDTH-1:0]         id_imm,
    input  logic                          id_reg_write,
    input  logic                          id_mem_read,
    input  logic                          id_mem_write,
    input  logic                          id_mem_to_reg,
    input  logic                          id_alu_src,
    input  logic                          id_reg_dst,
    input  logic [ALU_OP_WIDTH-1:0]       id_alu_op,
    input  logic                          flush,
    input  logic                          ext_stall,
    output logic                          ex_valid,
    output logic                          ex_reg_write,
    output logic                          ex_mem_read,
    output logic                          ex_mem_write,
    output logic                          ex_mem_to_reg,
    output logic                          ex_alu_src,
    output logic [ALU_OP_WIDTH-1:0]       ex_alu_op,
    output logic [REG_ADDRESS_LENGTH-1:0] ex_rs,
    output logic [REG_ADDRESS_LENGTH-1:0] ex_rt,
    output logic [REG_ADDRESS_LENGTH-1:0] ex_dest,
    output logic [DATA_WIDTH-1:0]         ex_rs_data,
    output logic [DATA_WIDTH-1:0]         ex_rt_data,
    output logic [DATA_WIDTH-1:0]         ex_imm,
    output logic                          hold_if_id,
    output logic                          lu_stall
);
    pipeStateT state, nextState;
    logic luHit, advance, issue;

    load_use_detect #(.REG_ADDRESS_LENGTH(REG_ADDRESS_LENGTH)) uLoadUseDetect (
        .exValid   (ex_valid),
        .exMemRead (ex_mem_read),
        .exDest    (ex_dest),
        .idValid   (id_valid),
        .idRs      (id_rs),
        .idRt      (id_rt),
        .luHit     (luHit)
    );

    // flush overrides a freeze; a flush or a load-use hit turns the slot into a bubble
    assign advance = flush | ~ext_stall;
    assign issue = id_valid & ~flush & ~luHit;
    assign lu_stall = (state == BUBBLE);

    // Next state and upstream freeze, priority flush > ext_stall > load-use
    always_comb begin
        nextState = RUN;
        hold_if_id = 1'b0;
        if (!flush && ext_stall) begin
            nextState = HOLD;
            hold_if_id = 1'b1;
        end else if (!flush && luHit) begin
            nextState = BUBBLE;
            hold_if_id = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else state <= nextState;
    end

    // EX-stage fields: controls are zeroed for bubbles, data is loaded regardless
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_alu_op     <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_dest       <= '0;
            ex_rs_data    <= '0;
            ex_rt_data    <= '0;
            ex_imm        <= '0;
        end else if (advance) begin
            ex_valid      <= issue;
            ex_reg_write  <= issue & id_reg_write;
            ex_mem_read   <= issue & id_mem_read;
            ex_mem_write  <= issue & id_mem_write;
            ex_mem_to_reg <= issue & id_mem_to_reg;
            ex_alu_src    <= issue & id_alu_src;
            ex_alu_op     <= issue ? id_alu_op : '0;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_dest       <= id_reg_dst ? id_rd : id_rt;
            ex_rs_data    <= id_rs_data;
            ex_rt_data    <= id_rt_data;
            ex_imm        <= id_imm;
        end
    end
endmodule

// File: doc/id_ex_pipe_reg.md
ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

Interface
REQ-001 SHALL have parameters: REG_ADDRESS_LENGTH, default 5 (from defines.v), register-address width; DATA_WIDTH, default 32, operand width.
REQ-002 SHALL have ports: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-003 id_valid input 1, ID slot holds a real instruction.
REQ-004 id_rs, id_rt, id_rd input REG_ADDRESS_LENGTH each, decoded register addresses.
REQ-005 id_rs_data, id_rt_data, id_imm input DATA_WIDTH each, register-file reads and sign-extended immediate.
REQ-006 id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst input 1 each; id_alu_op input 4; decoded controls.
REQ-007 flush input 1, branch/jump taken resolved in EX, kills the ID-stage instruction.
REQ-008 ext_stall input 1, downstream memory not ready, freeze this stage.
REQ-009 ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src output 1 each; ex_alu_op output 4.
REQ-010 ex_rs, ex_rt, ex_dest output REG_ADDRESS_LENGTH each; Rs/Rt to forwarding unit, dest = selected write address.
REQ-011 ex_rs_data, ex_rt_data, ex_imm output DATA_WIDTH each.
REQ-012 hold_if_id output 1, combinational, freeze PC and IF/ID register this cycle.
REQ-013 lu_stall output 1, registered, high for the cycle a load-use bubble sits in EX.

Function
REQ-014 All ex_* outputs SHALL be registered; latency ID->EX exactly one clock.
REQ-015 ex_dest SHALL capture id_reg_dst ? id_rd : id_rt.
REQ-016 Load-use hazard (lu_hit) SHALL be: ex_valid & ex_mem_read & ex_dest!=0 & id_valid & (ex_dest==id_rs | ex_dest==id_rt).
REQ-017 FSM states RUN, BUBBLE, HOLD; per-edge priority: rst > flush > ext_stall > lu_hit > normal.
REQ-018 flush=1: load bubble (ex_valid=0, all ex_* control bits 0), go RUN, hold_if_id=0, regardless of ext_stall or lu_hit.
REQ-019 ext_stall=1 (no flush): all ex_* retain values, go HOLD, hold_if_id=1.
REQ-020 lu_hit (no flush, no ext_stall): load bubble, go BUBBLE, lu_stall=1 next cycle, hold_if_id=1 this cycle.
REQ-021 Normal: load ID fields with ex_valid=id_valid; invalid ID SHALL load zero control bits; go RUN.
REQ-022 BUBBLE SHALL last exactly one cycle; re-evaluate lu_hit against the bubble (never true), so the held instruction issues next cycle.
REQ-023 HOLD SHALL exit to RUN on the first edge with ext_stall=0, applying REQ-020/021 that edge.
REQ-024 Data fields (ex_*_data, ex_imm, addresses) in a bubble are don't-care; control bits SHALL be 0.
REQ-025 Register 0 as destination SHALL never trigger lu_hit.

Reset
REQ-026 rst SHALL asynchronously force state RUN and all ex_* outputs and lu_stall to 0.
REQ-027 Reset mid-BUBBLE or mid-HOLD SHALL discard the pending instruction; first post-reset edge loads ID normally.

Structure
REQ-028 REG_ADDRESS_LENGTH, ALU-op width, FSM state encodings SHALL live in shared defines.v.
REQ-029 Load-use comparator SHALL be one sub-module, load_use_detect, combinational.

Verification
REQ-030 lw to r3 in EX (mem_read=1,dest=3), ID add rs=3 -> hold_if_id=1, next cycle ex_valid=0, lu_stall=1, following cycle ex_rs=3 ex_valid=1.
REQ-031 Same as 030 with dest=0 -> no stall, add issues next cycle.
REQ-032 ID instr valid, flush=1 and ext_stall=1 same cycle -> next cycle ex_valid=0, controls 0, hold_if_id=0.
REQ-033 ext_stall held 3 cycles with ex_rt_data=0xDEADBEEF -> value unchanged 3 cycles, hold_if_id=1 throughout, updates on fourth edge.
REQ-034 rst pulsed mid-BUBBLE -> all ex_* immediately 0 (asynchronous, before next edge), lu_stall=0.
REQ-035 id_reg_dst=1 rd=7 rt=9 -> ex_dest=7; id_reg_dst=0 -> ex_dest=9.
